// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline-stage registers: state encoding, RV32 NOP constant
// and the flush drop-amount helper.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FULL  = 2'd1;
  localparam logic [1:0] ST_SKID  = 2'd2;

  localparam logic [31:0] RV_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL,
    S_SKID  = ST_SKID
  } stage_state_t;

  // Beats lost on a flush: an unsent main entry, a held skid entry, and a same-cycle accept.
  function automatic logic [1:0] drop_amount(input logic main_v, input logic send,
                                             input logic skid_v, input logic accept);
    return {1'b0, main_v & ~send} + {1'b0, skid_v} + {1'b0, accept};
  endfunction

endpackage

// File: rtl/pipe_stage_skid_reg_sat_counter.sv
// Saturating up-counter that adds 0..3 per cycle and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH:0]   w_sum;

  // One extra bit catches any overflow past all-ones.
  assign w_sum = {1'b0, r_count} + (WIDTH+1)'(inc);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (w_sum[WIDTH]) begin
      r_count <= '1;
    end else begin
      r_count <= w_sum[WIDTH-1:0];
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid_reg.sv
// Pipeline-stage register with valid/ready handshake, 2-entry skid buffer, registered
// in_ready, flush-to-bubble and a saturating count of flushed beats.
module pipe_stage_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
  parameter int                 CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  drop_cnt
);

  stage_state_t      r_state, w_state_next;
  logic [DATA_W-1:0] r_main, w_main_next;
  logic [DATA_W-1:0] r_skid, w_skid_next;
  logic              r_in_ready;
  logic              w_accept, w_send, w_skid_valid;
  logic [1:0]        w_drop_inc;

  assign out_valid    = (r_state != S_EMPTY);
  assign w_skid_valid = (r_state == S_SKID);
  assign w_accept     = in_valid & r_in_ready;
  assign w_send       = out_valid & out_ready;

  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    w_drop_inc   = 2'd0;
    if (flush) begin
      w_state_next = S_EMPTY;
      w_drop_inc   = drop_amount(out_valid, w_send, w_skid_valid, w_accept);
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            w_state_next = S_FULL;
            w_main_next  = in_data;
          end
        end
        S_FULL: begin
          if (w_accept && w_send) begin
            w_main_next = in_data;
          end else if (w_send) begin
            w_state_next = S_EMPTY;
          end else if (w_accept) begin
            w_state_next = S_SKID;
            w_skid_next  = in_data;
          end
        end
        S_SKID: begin
          if (w_send) begin
            w_state_next = S_FULL;
            w_main_next  = r_skid;
            w_skid_next  = BUBBLE_VAL;
          end
        end
        default: w_state_next = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= S_EMPTY;
      r_main     <= BUBBLE_VAL;
      r_skid     <= BUBBLE_VAL;
      r_in_ready <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_main     <= w_main_next;
      r_skid     <= w_skid_next;
      // Ready for next cycle exactly when the skid entry will be free.
      r_in_ready <= (w_state_next != S_SKID);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (w_drop_inc),
    .count   (drop_cnt)
  );

  assign in_ready = r_in_ready;
  assign out_data = out_valid ? r_main : BUBBLE_VAL;

endmodule
